sd_cmd_engine: RTL and testbench

Parametrised SD-bus command engine: generates SDCLK with a runtime-selectable divider and performs the power-up clock burst. Serialises 48-bit commands with CRC7 onto CMD and captures 48-bit or 136-bit responses with timeout and CRC checking. Sits between the SD controller FSM (init/idle/read/write sequencing) and the CMD/SDCLK pads; the tristate pad buffer is outside this block.

---
 rtl/sd_cmd_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_sd_cmd_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_engine
// Description : SD-bus command engine. Generates SDCLK from a runtime divider,
//               performs the power-up clock burst, serialises 48-bit commands
//               with CRC7 on CMD and captures 48/136-bit responses with
//               timeout and CRC checking.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_engine #(
   parameter int DIV_W        = 9,
   parameter int DIV_INIT     = 200,
   parameter int INIT_CLKS    = 80,
   parameter int RESP_TIMEOUT = 64,
   parameter int GAP_CLKS     = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             start_i,
   input  logic [5:0]       cmd_idx_i,
   input  logic [31:0]      cmd_arg_i,
   input  logic [1:0]       resp_type_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic             crc_err_o,
   output logic [127:0]     resp_o,
   output logic             SDCLK_o,
   output logic             cmd_o,
   output logic             cmd_oe_o,
   input  logic             cmd_i
);

   // One shared bit/tick counter, wide enough for the longest phase.
   localparam int c_CNT_W = $clog2(INIT_CLKS + RESP_TIMEOUT + GAP_CLKS + 137);
   localparam logic [c_CNT_W-1:0] c_INIT_LAST = c_CNT_W'(INIT_CLKS - 1);
   localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(RESP_TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CLKS - 1);
   localparam logic [c_CNT_W-1:0] c_TX_LAST   = c_CNT_W'(47);
   localparam logic [c_CNT_W-1:0] c_R48_LAST  = c_CNT_W'(47);
   localparam logic [c_CNT_W-1:0] c_R136_LAST = c_CNT_W'(135);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [DIV_W-1:0]   c_DIV_INIT  = DIV_W'(DIV_INIT);
   localparam logic [DIV_W-1:0]   c_DIV_ONE   = DIV_W'(1);

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IDLE = 3'd1,
      S_SEND = 3'd2,
      S_WAIT = 3'd3,
      S_RECV = 3'd4,
      S_GAP  = 3'd5
   } state_t;

   state_t             r_state;
   logic [DIV_W-1:0]   r_div_q;
   logic [DIV_W-1:0]   r_div_cnt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [47:0]        r_tx;
   logic [1:0]         r_type;
   logic [126:0]       r_rx;

   logic               w_tick;
   logic               w_rise;
   logic               w_fall;
   logic               w_accept;
   logic [DIV_W-1:0]   w_div_sel;
   logic [6:0]         w_tx_crc;
   logic [6:0]         w_rx_crc;
   logic [127:0]       w_rx_next;

   // Serial CRC7 (x^7 + x^3 + 1, init 0) over 40 message bits, MSB first.
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 39; i >= 0; i--) begin
         fb     = data[i] ^ crc[6];
         crc    = {crc[5:0], fb};
         crc[3] = crc[3] ^ fb;
      end
      return crc;
   endfunction

   // Divider ticks, command accept, CRCs and the next receive shift value.
   always_comb begin
      w_tick    = (r_div_cnt >= (r_div_q - c_DIV_ONE));
      w_rise    = w_tick & ~SDCLK_o;
      w_fall    = w_tick & SDCLK_o;
      w_accept  = start_i & ~busy_o;
      w_div_sel = (div_i == '0) ? c_DIV_ONE : div_i;
      w_tx_crc  = crc7({2'b01, cmd_idx_i, cmd_arg_i});
      w_rx_next = {r_rx, cmd_i};
      w_rx_crc  = crc7(w_rx_next[47:8]);
   end

   // Free-running SDCLK divider; the >= compare keeps it safe when the
   // half-period shrinks while the counter is above the new terminal count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_div_cnt <= '0;
         r_div_q   <= c_DIV_INIT;
         SDCLK_o   <= 1'b0;
      end else begin
         if (w_accept) r_div_q <= w_div_sel;
         if (w_tick) begin
            r_div_cnt <= '0;
            SDCLK_o   <= ~SDCLK_o;
         end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
         end
      end
   end

   // Command/response sequencer; CMD changes on fall ticks, sampled on rises.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_INIT;
         r_cnt     <= '0;
         r_tx      <= '0;
         r_type    <= 2'b00;
         r_rx      <= '0;
         cmd_o     <= 1'b1;
         cmd_oe_o  <= 1'b1;
         busy_o    <= 1'b1;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         crc_err_o <= 1'b0;
         resp_o    <= '0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (w_rise) begin
                  if (r_cnt == c_INIT_LAST) begin
                     r_cnt   <= '0;
                     busy_o  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            S_IDLE: begin
               if (w_fall) begin
                  cmd_o    <= 1'b1;
                  cmd_oe_o <= 1'b1;
               end
               if (w_accept) begin
                  r_tx      <= {2'b01, cmd_idx_i, cmd_arg_i, w_tx_crc, 1'b1};
                  r_type    <= resp_type_i;
                  r_cnt     <= '0;
                  busy_o    <= 1'b1;
                  timeout_o <= 1'b0;
                  crc_err_o <= 1'b0;
                  r_state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_fall) begin
                  cmd_o    <= r_tx[47];
                  cmd_oe_o <= 1'b1;
                  r_tx     <= {r_tx[46:0], 1'b0};
                  if (r_cnt == c_TX_LAST) begin
                     r_cnt   <= '0;
                     r_state <= (r_type == 2'b00) ? S_GAP : S_WAIT;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            S_WAIT: begin
               // The end bit is held for one full period before release.
               if (w_fall) cmd_oe_o <= 1'b0;
               if (w_rise) begin
                  if (!cmd_i) begin
                     r_rx    <= w_rx_next[126:0];
                     r_cnt   <= c_CNT_ONE;
                     r_state <= S_RECV;
                  end else if (r_cnt == c_TO_LAST) begin
                     r_cnt     <= '0;
                     timeout_o <= 1'b1;
                     r_state   <= S_GAP;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            S_RECV: begin
               if (w_rise) begin
                  r_rx <= w_rx_next[126:0];
                  if ((r_type == 2'b10 && r_cnt == c_R136_LAST) ||
                      (r_type != 2'b10 && r_cnt == c_R48_LAST)) begin
                     r_cnt   <= '0;
                     r_state <= S_GAP;
                     if (r_type == 2'b10) begin
                        resp_o <= w_rx_next;
                     end else begin
                        resp_o    <= {90'd0, w_rx_next[45:8]};
                        crc_err_o <= (r_type == 2'b01) &&
                                     (w_rx_crc != w_rx_next[7:1]);
                     end
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            S_GAP: begin
               if (w_fall) begin
                  cmd_o    <= 1'b1;
                  cmd_oe_o <= 1'b1;
               end
               if (w_rise) begin
                  if (r_cnt == c_GAP_LAST) begin
                     r_cnt   <= '0;
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_engine
// Description : Self-checking bench for sd_cmd_engine with a host-frame
//               decoder, a card response model and a done-time comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_engine;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [8:0]   div_i = 9'd1;
   logic         start_i = 1'b0;
   logic [5:0]   cmd_idx_i = '0;
   logic [31:0]  cmd_arg_i = '0;
   logic [1:0]   resp_type_i = 2'b00;
   logic         busy_o, done_o, timeout_o, crc_err_o;
   logic [127:0] resp_o;
   logic         SDCLK_o, cmd_o, cmd_oe_o;
   logic         cmd_i;
   logic         card_drv = 1'b1;

   int total = 0;
   int bad   = 0;

   // Open-drain style pad: host value while enabled, card value otherwise.
   assign cmd_i = cmd_oe_o ? cmd_o : card_drv;

   always #5 clk_i = ~clk_i;

   sd_cmd_engine #(
      .DIV_W(9), .DIV_INIT(2), .INIT_CLKS(80), .RESP_TIMEOUT(64), .GAP_CLKS(8)
   ) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .start_i(start_i),
      .cmd_idx_i(cmd_idx_i), .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i),
      .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
      .crc_err_o(crc_err_o), .resp_o(resp_o), .SDCLK_o(SDCLK_o),
      .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .cmd_i(cmd_i)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int v, input int lo, input int hi);
      total++;
      if (v < lo || v > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
      end
   endtask

   // CRC7 as the remainder of (msg * x^7) divided by x^7+x^3+1.
   function automatic logic [6:0] m_crc7(input logic [39:0] msg);
      logic [46:0] r;
      r = {msg, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] m_frame(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, m_crc7({2'b01, idx, arg}), 1'b1};
   endfunction

   // Model state
   logic [47:0]  exp_frame = '0;
   logic [47:0]  mon_frame = '0;
   logic [127:0] exp_resp = '0;
   logic         exp_to = 1'b0, exp_crc = 1'b0, exp_resp_chk = 1'b0;
   logic [135:0] card_bits = '0;
   int           card_len = 0;
   int           card_pos = -1;
   int           frame_cnt = 0;
   int           oe_low_cnt = 0;
   event         frame_ev;

   // Decode host frames on SDCLK rising edges.
   initial forever begin
      @(posedge SDCLK_o); #1;
      if (!rst_i && cmd_oe_o && !cmd_o) begin
         mon_frame = '0;
         for (int i = 46; i >= 0; i--) begin
            @(posedge SDCLK_o); #1;
            mon_frame[i] = cmd_o;
         end
         frame_cnt++;
         check("frame_vs_model", mon_frame, exp_frame);
         -> frame_ev;
      end
   end

   // Card: answers two SDCLK periods after the host end bit, driving on falls.
   initial forever begin
      @(frame_ev);
      if (card_len > 0) begin
         repeat (2) @(negedge SDCLK_o);
         for (int i = card_len - 1; i >= 0; i--) begin
            #1 card_drv = card_bits[i];
            card_pos = card_len - 1 - i;
            @(negedge SDCLK_o);
         end
         #1 card_drv = 1'b1;
         card_pos = -1;
      end
   end

   // Completion comparator against the model expectations.
   always @(negedge clk_i) begin
      if (!rst_i && done_o) begin
         check("done_timeout", timeout_o, exp_to);
         check("done_crc_err", crc_err_o, exp_crc);
         if (exp_resp_chk) check("done_resp", resp_o, exp_resp);
      end
   end

   // CMD may only change right after an SDCLK high->low transition.
   logic prev_cmd = 1'b1, prev_sd = 1'b0, prev_rst = 1'b1;
   always @(negedge clk_i) begin
      if (!rst_i && !prev_rst && cmd_o !== prev_cmd)
         check("cmd_on_fall", {prev_sd, SDCLK_o}, 2'b10);
      if (!cmd_oe_o) oe_low_cnt++;
      prev_cmd = cmd_o;
      prev_sd  = SDCLK_o;
      prev_rst = rst_i;
   end

   task automatic measure_init();
      int n = 0;
      int hi_bad = 0;
      while (busy_o === 1'b1 && n < 1000) begin
         if (cmd_o !== 1'b1 || cmd_oe_o !== 1'b1) hi_bad++;
         @(negedge clk_i);
         n++;
      end
      check_range("init_busy_cycles", n, 316, 324);
      check("init_cmd_high", hi_bad, 0);
   endtask

   task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
      int n = 0;
      while (busy_o !== 1'b0 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 2000) begin
         total++; bad++;
         $display("FAIL issue_wait: busy_o got %b expected 0", busy_o);
      end
      cmd_idx_i = idx; cmd_arg_i = arg; resp_type_i = typ; start_i = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
      exp_frame  = m_frame(idx, arg);
      mon_frame  = '0;
      oe_low_cnt = 0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done_o !== 1'b1 && cyc < 4000) begin
         @(negedge clk_i);
         cyc++;
      end
      if (cyc >= 4000) begin
         total++; bad++;
         $display("FAIL done_wait: done_o got %b expected 1", done_o);
      end
   endtask

   task automatic set_card48(input logic [47:0] bits, input logic [1:0] typ);
      card_bits    = {88'd0, bits};
      card_len     = 48;
      exp_resp     = {90'd0, bits[45:8]};
      exp_crc      = (typ == 2'b01) && (m_crc7(bits[47:8]) != bits[7:1]);
      exp_to       = 1'b0;
      exp_resp_chk = 1'b1;
   endtask

   localparam logic [127:0] CID = 128'h0353_4453_4330_3847_8012_3456_7801_2E31;

   initial begin
      int cyc;
      int fc;
      int n;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_sdclk", SDCLK_o, 1'b0);
      check("rst_cmd", cmd_o, 1'b1);
      check("rst_oe", cmd_oe_o, 1'b1);
      check("rst_busy", busy_o, 1'b1);
      check("rst_done", done_o, 1'b0);
      check("rst_flags", {timeout_o, crc_err_o}, 2'b00);
      check("rst_resp", resp_o, 128'd0);
      rst_i = 1'b0;
      measure_init();
      check("idle_after_init", busy_o, 1'b0);

      // Model pins for the CRC helper.
      check("model_crc_cmd0", m_crc7(40'h40_0000_0000), 7'h4A);
      check("model_crc_cmd8", m_crc7(40'h48_0000_01AA), 7'h43);

      // CMD0, no response.
      card_len = 0; exp_to = 0; exp_crc = 0; exp_resp_chk = 0;
      issue(6'd0, 32'd0, 2'b00);
      wait_done(cyc);
      check("cmd0_frame", mon_frame, 48'h40_0000_0000_95);
      check("cmd0_oe_held", oe_low_cnt, 0);
      check_range("cmd0_latency_cycles", cyc, 110, 114);

      // CMD8 with a correct R7 response (back-to-back with the previous done).
      issue(6'd8, 32'h0000_01AA, 2'b01);
      set_card48(48'h08_0000_01AA_13, 2'b01);
      wait_done(cyc);
      check("cmd8_frame", mon_frame, 48'h48_0000_01AA_87);
      check("cmd8_resp", resp_o[37:0], {6'h08, 32'h0000_01AA});
      check("cmd8_crc_ok", crc_err_o, 1'b0);
      check("cmd8_oe_released", oe_low_cnt > 0, 1'b1);

      // Same, but a CRC bit corrupted (the end bit is outside the CRC).
      issue(6'd8, 32'h0000_01AA, 2'b01);
      set_card48(48'h08_0000_01AA_11, 2'b01);
      wait_done(cyc);
      check("cmd8bad_crc_err", crc_err_o, 1'b1);
      check("cmd8bad_resp", resp_o, {90'd0, 6'h08, 32'h0000_01AA});

      // R3: bad CRC field ignored.
      issue(6'd41, 32'h40FF_8000, 2'b11);
      set_card48(48'h3F_00FF_8000_FF, 2'b11);
      wait_done(cyc);
      check("r3_crc_ignored", crc_err_o, 1'b0);
      check("r3_resp", resp_o, {90'd0, 6'h3F, 32'h00FF_8000});

      // Silent card: timeout after 64 rise ticks plus gap.
      card_len = 0;
      issue(6'd55, 32'd0, 2'b01);
      exp_to = 1; exp_crc = 0; exp_resp_chk = 0;
      wait_done(cyc);
      check("silent_timeout", timeout_o, 1'b1);
      check_range("silent_latency_cycles", cyc, 238, 242);

      // 136-bit CID response with a start_i pulse in the middle of it.
      issue(6'd2, 32'd0, 2'b10);
      card_bits = {8'h3F, CID}; card_len = 136;
      exp_resp = CID; exp_to = 0; exp_crc = 0; exp_resp_chk = 1;
      n = 0;
      while (card_pos < 60 && n < 2000) begin @(negedge clk_i); n++; end
      check("cid_reached_mid", n < 2000, 1'b1);
      fc = frame_cnt;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done(cyc);
      check("cid_resp", resp_o, CID);
      repeat (200) @(negedge clk_i);
      check("cid_start_ignored_frames", frame_cnt, fc);
      check("cid_start_ignored_busy", busy_o, 1'b0);

      // Reset in the middle of a 136-bit response.
      issue(6'd2, 32'd0, 2'b10);
      card_bits = {8'h3F, CID}; card_len = 136;
      n = 0;
      while (card_pos < 50 && n < 2000) begin @(negedge clk_i); n++; end
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      check("midrst_busy", busy_o, 1'b1);
      check("midrst_cmd", {cmd_oe_o, cmd_o}, 2'b11);
      check("midrst_sdclk", SDCLK_o, 1'b0);
      check("midrst_done", done_o, 1'b0);
      rst_i = 1'b0;
      measure_init();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time got 2000000 expected less");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
